// File: rtl/icmp_encoder.sv
// ICMP echo-reply encoder: folds the reply checksum, emits the 8-byte header,
// then forwards the buffered payload from the decoder FIFO with underrun detection.
module icmp_encoder #(
    parameter int unsigned REQ_LEAD = 2,
    parameter int unsigned LEN_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       in_type,
    input  logic [67:0]      hdr,
    input  logic [LEN_W-1:0] data_len,
    output logic             data_req,
    input  logic [7:0]       in_data,
    input  logic             in_data_vld,
    output logic [7:0]       out_data,
    output logic             out_data_vld,
    output logic             out_last,
    output logic             busy,
    output logic             err,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned SUM_W   = 22;
    localparam int unsigned REQ_POS = 9 - REQ_LEAD;

    typedef enum logic [2:0] {IDLE, CALC1, CALC2, HDR, PAYLOAD} state_t;

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx;
    logic [LEN_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       code_q;
    logic [15:0]      id_q, seq_q;
    logic [19:0]      dcs_q;
    logic [SUM_W-1:0] sum_q, sum_nx;
    logic [15:0]      csum_q, csum_nx;
    logic [16:0]      fold1;
    logic [15:0]      fold2;
    logic             lat;
    logic [2:0]       hdr_sel;
    logic [7:0]       hdr_byte;
    logic [7:0]       out_data_nx, drop_nx;
    logic             out_vld_nx, out_last_nx, busy_nx, err_nx, data_req_nx;
    logic             unused_type;

    // The request TYPE field is replaced by 0 in the reply and never read.
    assign unused_type = ^hdr[7:0];

    assign cnt_inc = cnt + LEN_W'(1);
    assign fold1   = 17'(sum_q[15:0]) + 17'(sum_q[21:16]);
    assign fold2   = fold1[15:0] + 16'(fold1[16]);
    assign hdr_sel = idx + 3'd1;

    // Header byte that follows the one currently on out_data.
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_sel)
            3'd1:    hdr_byte = code_q;
            3'd2:    hdr_byte = csum_q[15:8];
            3'd3:    hdr_byte = csum_q[7:0];
            3'd4:    hdr_byte = id_q[15:8];
            3'd5:    hdr_byte = id_q[7:0];
            3'd6:    hdr_byte = seq_q[15:8];
            3'd7:    hdr_byte = seq_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cnt_nx      = cnt;
        sum_nx      = sum_q;
        csum_nx     = csum_q;
        lat         = 1'b0;
        out_data_nx = 8'h00;
        out_vld_nx  = 1'b0;
        out_last_nx = 1'b0;
        err_nx      = 1'b0;
        data_req_nx = 1'b0;
        busy_nx     = busy;
        drop_nx     = drop_cnt;

        if (start && busy && drop_cnt != 8'hFF)
            drop_nx = drop_cnt + 8'd1;

        case (state)
            IDLE: begin
                if (start && in_type == 2'b01) begin
                    lat      = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = CALC1;
                end
            end
            CALC1: begin
                sum_nx   = SUM_W'(code_q) + SUM_W'(id_q) + SUM_W'(seq_q) + SUM_W'(dcs_q);
                state_nx = CALC2;
            end
            CALC2: begin
                csum_nx     = ~fold2;
                idx_nx      = 3'd0;
                out_vld_nx  = 1'b1;
                data_req_nx = (REQ_POS == 2) && (len_q != '0);
                state_nx    = HDR;
            end
            HDR, PAYLOAD: begin
                if (state == HDR && idx != 3'd7) begin
                    idx_nx      = idx + 3'd1;
                    out_data_nx = hdr_byte;
                    out_vld_nx  = 1'b1;
                    out_last_nx = (idx == 3'd6) && (len_q == '0);
                    data_req_nx = (len_q != '0) && (4'(idx) + 4'd3 == 4'(REQ_POS));
                end else if (out_last) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    // A missing byte closes the frame with a zero filler flagged as error.
                    out_vld_nx  = 1'b1;
                    state_nx    = PAYLOAD;
                    if (in_data_vld) begin
                        out_data_nx = in_data;
                        cnt_nx      = cnt_inc;
                        out_last_nx = (cnt_inc == len_q);
                    end else begin
                        out_last_nx = 1'b1;
                        err_nx      = 1'b1;
                    end
                end
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 3'd0;
            cnt          <= '0;
            len_q        <= '0;
            code_q       <= 8'h00;
            id_q         <= 16'h0000;
            seq_q        <= 16'h0000;
            dcs_q        <= 20'h00000;
            sum_q        <= '0;
            csum_q       <= 16'h0000;
            out_data     <= 8'h00;
            out_data_vld <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            data_req     <= 1'b0;
            drop_cnt     <= 8'h00;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            cnt          <= cnt_nx;
            sum_q        <= sum_nx;
            csum_q       <= csum_nx;
            out_data     <= out_data_nx;
            out_data_vld <= out_vld_nx;
            out_last     <= out_last_nx;
            busy         <= busy_nx;
            err          <= err_nx;
            data_req     <= data_req_nx;
            drop_cnt     <= drop_nx;
            if (lat) begin
                len_q  <= data_len;
                cnt    <= '0;
                seq_q  <= hdr[67:52];
                id_q   <= hdr[51:36];
                dcs_q  <= hdr[35:16];
                code_q <= hdr[15:8];
            end
        end
    end

endmodule
